// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types for the next-PC redirect controller.
//   pc_src_t      : encoding of the next-PC mux select
//   redir_state_t : controller sequencing states
package rv_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_JALR   = 2'b01,
    PC_TARGET = 2'b10
  } pc_src_t;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    PEND = 2'b10
  } redir_state_t;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Bundle of EX-stage resolution, hazard and fetch-control signals around
// pc_redirect_ctrl.
//   slave  : the controller (consumes EX/hazard/imem inputs, drives controls)
//   master : the surrounding pipeline (drives inputs, observes controls)
// Signals: jump_e, jalr_e, branch_e, branch_taken_e, pc_target_e, pc_jalr_e,
//          load_use_hz, imem_ready  -> controller
//          pc_src, redirect_pc, stall_f, stall_d, flush_d, flush_e,
//          redirect_cnt, dbg_state  <- controller
// Handshake: imem_ready is a per-cycle ready; a PC presented while it is low
// is not accepted and must be presented again. There is no valid qualifier,
// because fetch always presents a PC.
interface pc_redirect_ctrl_if #(
  parameter int N     = 32,
  parameter int CNT_W = 32
);
  import rv_pkg::*;

  logic             jump_e;
  logic             jalr_e;
  logic             branch_e;
  logic             branch_taken_e;
  logic [N-1:0]     pc_target_e;
  logic [N-1:0]     pc_jalr_e;
  logic             load_use_hz;
  logic             imem_ready;
  pc_src_t          pc_src;
  logic [N-1:0]     redirect_pc;
  logic             stall_f;
  logic             stall_d;
  logic             flush_d;
  logic             flush_e;
  logic [CNT_W-1:0] redirect_cnt;
  redir_state_t     dbg_state;

  modport slave (
    input  jump_e, jalr_e, branch_e, branch_taken_e, pc_target_e, pc_jalr_e,
           load_use_hz, imem_ready,
    output pc_src, redirect_pc, stall_f, stall_d, flush_d, flush_e,
           redirect_cnt, dbg_state
  );

  modport master (
    output jump_e, jalr_e, branch_e, branch_taken_e, pc_target_e, pc_jalr_e,
           load_use_hz, imem_ready,
    input  pc_src, redirect_pc, stall_f, stall_d, flush_d, flush_e,
           redirect_cnt, dbg_state
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Next-PC sequencing controller for the pipelined RV32I core.
// Chooses PC+4 / live JALR target / branch-JAL-or-held target each cycle and
// drives the fetch/decode stall and flush controls. A redirect that meets a
// not-ready instruction memory is parked in a held register (PEND) until
// fetch accepts it. After reset, fetch is held for BOOT_CYCLES cycles.
// Ports:
//   clk  : core clock
//   rst  : synchronous active-high reset
//   bus  : pc_redirect_ctrl_if.slave (EX/hazard/imem in, controls out)
module pc_redirect_ctrl
  import rv_pkg::*;
#(
  parameter int N           = 32,
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  pc_redirect_ctrl_if.slave   bus
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  redir_state_t     r_state, w_state_nx;
  logic [BW-1:0]    r_boot_cnt;
  logic [N-1:0]     r_held;
  logic [CNT_W-1:0] r_redirect_cnt;

  logic             w_take;
  logic [N-1:0]     w_live_tgt;
  logic             w_accept;     // redirect counted this cycle
  logic             w_capture;    // park live target in r_held
  pc_src_t          w_pc_src;
  logic [N-1:0]     w_redirect_pc;
  logic             w_stall_f, w_stall_d, w_flush_d, w_flush_e;

  assign w_take     = bus.jump_e | bus.jalr_e | (bus.branch_e & bus.branch_taken_e);
  assign w_live_tgt = bus.jalr_e ? bus.pc_jalr_e : bus.pc_target_e;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= BOOT;
      r_boot_cnt     <= BW'(BOOT_CYCLES - 1);
      r_held         <= '0;
      r_redirect_cnt <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == BOOT && r_boot_cnt != '0)
        r_boot_cnt <= r_boot_cnt - BW'(1);
      if (w_capture)
        r_held <= w_live_tgt;
      if (w_accept)
        r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_accept      = 1'b0;
    w_capture     = 1'b0;
    w_pc_src      = PC_SEQ;
    w_redirect_pc = bus.pc_target_e;
    w_stall_f     = 1'b0;
    w_stall_d     = 1'b0;
    w_flush_d     = 1'b0;
    w_flush_e     = 1'b0;

    if (rst) begin
      w_redirect_pc = '0;
      w_stall_f     = 1'b1;
      w_stall_d     = 1'b1;
      w_flush_d     = 1'b1;
      w_flush_e     = 1'b1;
    end else begin
      unique case (r_state)
        BOOT: begin
          w_stall_f = 1'b1;
          w_flush_d = 1'b1;
          w_flush_e = 1'b1;
          if (r_boot_cnt == '0) w_state_nx = RUN;
        end
        RUN: begin
          if (w_take) begin
            // Redirect beats load-use: the D instruction is wrong-path anyway.
            w_pc_src  = bus.jalr_e ? PC_JALR : PC_TARGET;
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
            w_accept  = 1'b1;
            if (!bus.imem_ready) begin
              w_stall_f  = 1'b1;
              w_capture  = 1'b1;
              w_state_nx = PEND;
            end
          end else if (!bus.imem_ready) begin
            w_stall_f = 1'b1;
            w_flush_d = 1'b1;
          end else if (bus.load_use_hz) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
          end
        end
        PEND: begin
          // Held target (JAL, branch or JALR) always goes through mux in2.
          w_pc_src      = PC_TARGET;
          w_redirect_pc = r_held;
          w_flush_d     = 1'b1;
          w_flush_e     = 1'b1;
          w_stall_f     = !bus.imem_ready;
          if (bus.imem_ready) w_state_nx = RUN;
        end
        default: w_state_nx = BOOT;
      endcase
    end
  end

  assign bus.pc_src       = w_pc_src;
  assign bus.redirect_pc  = w_redirect_pc;
  assign bus.stall_f      = w_stall_f;
  assign bus.stall_d      = w_stall_d;
  assign bus.flush_d      = w_flush_d;
  assign bus.flush_e      = w_flush_e;
  assign bus.redirect_cnt = r_redirect_cnt;
  assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;
  import rv_pkg::*;

  localparam int N     = 32;
  localparam int CNT_W = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pc_redirect_ctrl_if #(.N(N), .CNT_W(CNT_W)) bus ();

  pc_redirect_ctrl #(.N(N), .BOOT_CYCLES(2), .CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // check the four pipeline controls as a packed {stall_f,stall_d,flush_d,flush_e}
  task automatic check_ctl(input string tag, input logic [3:0] exp);
    check(tag, {60'd0, bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e}, {60'd0, exp});
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic jump, input logic jalr, input logic br,
                          input logic taken, input logic [N-1:0] tgt,
                          input logic [N-1:0] jtgt);
    bus.jump_e         = jump;
    bus.jalr_e         = jalr;
    bus.branch_e       = br;
    bus.branch_taken_e = taken;
    bus.pc_target_e    = tgt;
    bus.pc_jalr_e      = jtgt;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h55, 32'h66);
    bus.load_use_hz = 1'b0;
    bus.imem_ready  = 1'b1;

    // reset: outputs forced regardless of inputs
    @(posedge clk);
    settle();
    check("rst_pc_src", 64'(bus.pc_src), 64'(2'b00));
    check("rst_redirect_pc", 64'(bus.redirect_pc), 64'h0);
    check_ctl("rst_ctl", 4'b1111);
    tick();
    check("rst_state", 64'(bus.dbg_state), 64'(BOOT));
    check("rst_cnt", 64'(bus.redirect_cnt), 64'h0);
    rst = 1'b0;

    // boot: two cycles, EX take ignored
    drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
    settle();
    check("boot1_state", 64'(bus.dbg_state), 64'(BOOT));
    check("boot1_pc_src", 64'(bus.pc_src), 64'(2'b00));
    check_ctl("boot1_ctl", 4'b1011);
    tick();
    check("boot2_state", 64'(bus.dbg_state), 64'(BOOT));
    check_ctl("boot2_ctl", 4'b1011);
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("run_state", 64'(bus.dbg_state), 64'(RUN));
    check("run_pc_src", 64'(bus.pc_src), 64'(2'b00));
    check_ctl("run_idle_ctl", 4'b0000);
    check("boot_cnt_zero", 64'(bus.redirect_cnt), 64'h0);

    // taken branch, memory ready: zero-latency redirect
    drive_ex(1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0);
    settle();
    check("br_pc_src", 64'(bus.pc_src), 64'(2'b10));
    check("br_redirect_pc", 64'(bus.redirect_pc), 64'h100);
    check_ctl("br_ctl", 4'b0011);
    tick();
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    check("br_cnt", 64'(bus.redirect_cnt), 64'h1);

    // branch not taken: no redirect
    drive_ex(1'b0, 1'b0, 1'b1, 1'b0, 32'h180, 32'h0);
    settle();
    check("nt_pc_src", 64'(bus.pc_src), 64'(2'b00));
    check_ctl("nt_ctl", 4'b0000);
    tick();
    check("nt_cnt", 64'(bus.redirect_cnt), 64'h1);

    // JALR with coincident load-use: redirect wins, no stall
    drive_ex(1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h204);
    bus.load_use_hz = 1'b1;
    settle();
    check("jalr_pc_src", 64'(bus.pc_src), 64'(2'b01));
    check("jalr_redirect_pc", 64'(bus.redirect_pc), 64'h300);
    check_ctl("jalr_lu_ctl", 4'b0011);
    tick();
    bus.load_use_hz = 1'b0;
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    check("jalr_cnt", 64'(bus.redirect_cnt), 64'h2);

    // JAL with memory not ready: park target, then 3 PEND stall cycles
    drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
    bus.imem_ready = 1'b0;
    settle();
    check("jal_nr_ctl", 4'b0000 | 64'({bus.stall_f, bus.flush_d, bus.flush_e}), 64'(3'b111));
    for (int i = 0; i < 3; i++) begin
      tick();
      // EX junk during PEND must be ignored
      drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h999, 32'h777);
      settle();
      check("pend_state", 64'(bus.dbg_state), 64'(PEND));
      check("pend_pc_src", 64'(bus.pc_src), 64'(2'b10));
      check("pend_redirect_pc", 64'(bus.redirect_pc), 64'h40);
      check_ctl("pend_ctl", 4'b1011);
    end
    check("pend_cnt", 64'(bus.redirect_cnt), 64'h3);
    bus.imem_ready = 1'b1;
    settle();
    check_ctl("pend_rdy_ctl", 4'b0011);
    check("pend_rdy_redirect_pc", 64'(bus.redirect_pc), 64'h40);
    tick();
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    check("pend_exit_state", 64'(bus.dbg_state), 64'(RUN));
    check("pend_exit_cnt", 64'(bus.redirect_cnt), 64'h3);

    // load-use alone: one stall cycle
    bus.load_use_hz = 1'b1;
    settle();
    check("lu_pc_src", 64'(bus.pc_src), 64'(2'b00));
    check_ctl("lu_ctl", 4'b1101);
    tick();
    bus.load_use_hz = 1'b0;
    settle();
    check_ctl("lu_clear_ctl", 4'b0000);

    // memory stall with load-use: imem stall wins, bubble into D
    bus.imem_ready  = 1'b0;
    bus.load_use_hz = 1'b1;
    settle();
    check_ctl("imem_stall_ctl", 4'b1010);
    tick();
    check("imem_stall_state", 64'(bus.dbg_state), 64'(RUN));
    bus.load_use_hz = 1'b0;

    // JALR parked in PEND, then reset mid-PEND
    drive_ex(1'b0, 1'b1, 1'b0, 1'b0, 32'h500, 32'h80);
    tick();
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    check("pend2_redirect_pc", 64'(bus.redirect_pc), 64'h80);
    check("pend2_cnt", 64'(bus.redirect_cnt), 64'h4);
    rst = 1'b1;
    settle();
    check("pend_rst_redirect_pc", 64'(bus.redirect_pc), 64'h0);
    check("pend_rst_pc_src", 64'(bus.pc_src), 64'(2'b00));
    tick();
    rst = 1'b0;
    bus.imem_ready = 1'b1;
    settle();
    check("post_rst_state", 64'(bus.dbg_state), 64'(BOOT));
    check("post_rst_cnt", 64'(bus.redirect_cnt), 64'h0);
    check("post_rst_pc_src", 64'(bus.pc_src), 64'(2'b00));
    tick();
    tick();
    check("post_rst_run", 64'(bus.dbg_state), 64'(RUN));

    // summary
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #20000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Sequencing controller for the next-PC select mux of the pipelined RV32I core.
- Decides each cycle between PC+4, live JALR target, and branch/JAL or held-redirect target; drives the select and the pipeline stall/flush controls.
- Holds a redirect when instruction memory is not ready, and runs a short boot hold after reset.
- Sits between the EX-stage branch/jump resolution, the hazard unit and the fetch stage. The next-PC mux `branch` input is tied low when this block is used.

Parameters:
N, 32, PC/address width
BOOT_CYCLES, 2, cycles fetch is held after reset release (>=1)
CNT_W, 32, width of redirect performance counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
jump_e  in  1  JAL in EX
jalr_e  in  1  JALR in EX
branch_e  in  1  conditional branch in EX
branch_taken_e  in  1  branch comparator result (valid with branch_e)
pc_target_e  in  N  branch/JAL target from EX
pc_jalr_e  in  N  JALR target from EX
load_use_hz  in  1  load-use hazard from hazard unit
imem_ready  in  1  instruction memory accepts PC this cycle
pc_src  out  2  next-PC select: 00 PC+4, 01 live JALR, 10 redirect_pc; 11 never driven
redirect_pc  out  N  value for mux in2: live pc_target_e or held target
stall_f  out  1  hold PC register
stall_d  out  1  hold IF/ID register
flush_d  out  1  clear IF/ID register
flush_e  out  1  clear ID/EX register
redirect_cnt  out  CNT_W  count of accepted redirects (wraps)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst. All state updates on rising clk.
- Definitions:
  - take = jump_e | jalr_e | (branch_e & branch_taken_e).
  - Live target = pc_jalr_e if jalr_e, else pc_target_e.
- States: BOOT, RUN, PEND.
- Reset:
  - state=BOOT, boot counter=BOOT_CYCLES-1, held target=0, redirect_cnt=0.
  - Outputs during rst: pc_src=00, redirect_pc=0, stall_f=1, stall_d=1, flush_d=1, flush_e=1.
- BOOT:
  - stall_f=1, flush_d=1, flush_e=1, pc_src=00.
  - Counter decrements each cycle; leave to RUN on the cycle after it reads 0.
  - EX inputs are ignored.
- RUN, priority redirect > imem stall > load-use:
  - take & imem_ready:
    - pc_src=01 if jalr_e, else 10; redirect_pc=pc_target_e.
    - flush_d=1, flush_e=1, stall_f=0, stall_d=0; redirect_cnt++.
    - Same cycle, zero latency.
  - take & !imem_ready:
    - Capture live target into held register; go to PEND.
    - flush_d=1, flush_e=1, stall_f=1; redirect_cnt++.
    - pc_src/redirect_pc as for the live case (don't-care, PC not loaded).
  - !take & !imem_ready: stall_f=1, flush_d=1 (bubble into D), stall_d=0.
  - !take & load_use_hz: stall_f=1, stall_d=1, flush_e=1, pc_src=00.
  - Load-use coincident with take: redirect wins; no stall, because the D instruction is wrong-path.
  - Otherwise: pc_src=00, all controls 0.
- PEND:
  - pc_src=10, redirect_pc=held; flush_d=1, flush_e=1.
  - stall_f=!imem_ready.
  - On imem_ready, go to RUN the next cycle.
  - EX inputs are ignored; EX holds bubbles only.
- Arithmetic: redirect_cnt wraps modulo 2^CNT_W. No other arithmetic; no PC computation inside the block.
- rst asserted in any state, including mid-PEND: next cycle is BOOT, the held target is discarded, and redirect_cnt clears.
- Outputs are combinational from state and inputs. Only state, boot counter, held target and redirect_cnt are registered.

Decomposition:
- Shared package rv_pkg:
  - pc_src_t enum PC_SEQ=2'b00, PC_JALR=2'b01, PC_TARGET=2'b10.
  - redir_state_t enum BOOT, RUN, PEND.
- Single module; no sub-module needed. The boot counter and perf counter are inline.

Test Plan:
- rst=1 for 2 cycles, then 0 with BOOT_CYCLES=2 -> stall_f=1 and flush_d=1 for exactly 2 cycles after release; RUN on 3rd cycle with pc_src=00; redirect_cnt=0.
- RUN, branch_e=1, branch_taken_e=1, pc_target_e=0x0000_0100, imem_ready=1 -> same cycle pc_src=10, redirect_pc=0x100, flush_d=flush_e=1; redirect_cnt=1 next cycle.
- RUN, jalr_e=1, pc_jalr_e=0x0000_0204, load_use_hz=1 -> pc_src=01, flush_d=flush_e=1, stall_f=stall_d=0.
- RUN, jump_e=1, pc_target_e=0x0000_0040, imem_ready=0 for 3 cycles, then 1:
  - PEND with pc_src=10, redirect_pc=0x40, stall_f=1 for 3 cycles.
  - stall_f=0 on the ready cycle; RUN after.
- RUN, load_use_hz=1, no take, imem_ready=1 -> stall_f=stall_d=1, flush_e=1, pc_src=00 for one cycle.
- In PEND with held=0x80, assert rst -> next cycle BOOT, held=0, redirect_cnt=0, pc_src=00.
